// File: rtl/bios_wdt_timer.sv
// ---------------------------------------------------------------------------
// bios_wdt_timer
//   This module sits at the consumer end of the BIOS watchdog write path. It
//   receives five per-command toggle bits that are already in the CLK32768
//   domain. Each edge on a bit is decoded as one command. The commands drive
//   the BIOS watchdog: arm, kick, stop, clear and bad-command. When the
//   watchdog expires, the module raises a one-cycle reset request to the
//   reset/power sequencer.
//
//   Ports
//     CLK32768        in   32.768 kHz clock (sole clock)
//     MainResetN      in   async active-low reset
//     bCPUWrWdtRegSig in   [0]=ARM [1]=KICK [2]=STOP [3]=CLEAR [4]=BADCMD toggles
//     WdtEnable       out  high while running
//     WdtWarn         out  high while running with WdtRemain <= WARN
//     WdtExpired      out  sticky expiry flag (cleared by CLEAR/reset)
//     WdtResetReq     out  one-cycle pulse following the expiry edge
//     WdtBadCmd       out  sticky bad-command flag (cleared by CLEAR/reset)
//     WdtRemain       out  remaining ticks
// ---------------------------------------------------------------------------
module bios_wdt_timer #(
  parameter int unsigned PRESCALE = 32768,
  parameter int unsigned REMW     = 8,
  parameter int unsigned TIMEOUT  = 180,
  parameter int unsigned WARN     = 10
) (
  input  logic            CLK32768,
  input  logic            MainResetN,
  input  logic [4:0]      bCPUWrWdtRegSig,
  output logic            WdtEnable,
  output logic            WdtWarn,
  output logic            WdtExpired,
  output logic            WdtResetReq,
  output logic            WdtBadCmd,
  output logic [REMW-1:0] WdtRemain
);

  localparam int unsigned     PSW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PSW-1:0]  PS_LAST  = PSW'(PRESCALE - 1);
  localparam logic [REMW-1:0] REM_LOAD = REMW'(TIMEOUT);
  localparam logic [REMW-1:0] REM_WARN = REMW'(WARN);
  localparam logic [REMW-1:0] REM_ONE  = REMW'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_EXPIRED
  } state_t;

  state_t          state_q, state_d;
  logic [4:0]      sync_q, prev_q;
  logic [PSW-1:0]  presc_q, presc_d;
  logic [REMW-1:0] remain_q, remain_d;
  logic            expired_q, expired_d;
  logic            badcmd_q, badcmd_d;
  logic            resetreq_q;

  logic [4:0] cmd;
  logic       cmd_stop, cmd_arm, cmd_kick, cmd_clear, cmd_bad;
  logic       tick, reload, expire;

  // A change on s1 relative to its previous value is one command. This holds
  // for both directions of the toggle.
  always_ff @(posedge CLK32768 or negedge MainResetN) begin
    if (!MainResetN) begin
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      sync_q <= bCPUWrWdtRegSig;
      prev_q <= sync_q;
    end
  end

  // State register
  always_ff @(posedge CLK32768 or negedge MainResetN) begin
    if (!MainResetN) state_q <= S_IDLE;
    else             state_q <= state_d;
  end

  // Counter and flag registers
  always_ff @(posedge CLK32768 or negedge MainResetN) begin
    if (!MainResetN) begin
      presc_q    <= '0;
      remain_q   <= REM_LOAD;
      expired_q  <= 1'b0;
      badcmd_q   <= 1'b0;
      resetreq_q <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      remain_q   <= remain_d;
      expired_q  <= expired_d;
      badcmd_q   <= badcmd_d;
      resetreq_q <= expire;
    end
  end

  // Next-state and datapath logic
  always_comb begin
    cmd       = sync_q ^ prev_q;
    // STOP beats ARM, and ARM beats KICK. CLEAR and BADCMD are independent.
    cmd_stop  = cmd[2];
    cmd_arm   = cmd[0] & ~cmd_stop;
    cmd_kick  = cmd[1] & ~cmd_stop & ~cmd[0];
    cmd_clear = cmd[3];
    cmd_bad   = cmd[4];

    tick   = (state_q == S_RUN) && (presc_q == PS_LAST);
    // KICK reloads only while running. ARM reloads from any state.
    reload = cmd_arm | (cmd_kick && (state_q == S_RUN));
    // A reload or a STOP on the final tick edge suppresses the expiry.
    expire = tick && !cmd_stop && !reload && (remain_q <= REM_ONE);

    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (cmd_arm) state_d = S_RUN;
      S_RUN: begin
        if      (cmd_stop) state_d = S_IDLE;
        else if (expire)   state_d = S_EXPIRED;
      end
      S_EXPIRED: begin
        if      (cmd_stop) state_d = S_IDLE;
        else if (cmd_arm)  state_d = S_RUN;
      end
      default:   state_d = S_IDLE;
    endcase

    presc_d = presc_q + PSW'(1);
    if (state_d != S_RUN || reload || tick) presc_d = '0;

    remain_d = remain_q;
    if (state_d == S_IDLE || reload)
      remain_d = REM_LOAD;
    else if (tick)
      remain_d = (remain_q == '0) ? '0 : remain_q - REM_ONE;

    // Expiry beats a coincident CLEAR. BADCMD beats a coincident CLEAR.
    expired_d = expire ? 1'b1 : (cmd_clear ? 1'b0 : expired_q);
    badcmd_d  = cmd_bad ? 1'b1 : (cmd_clear ? 1'b0 : badcmd_q);
  end

  // Output logic
  always_comb begin
    WdtEnable = (state_q == S_RUN);
    WdtWarn   = (state_q == S_RUN) && (remain_q <= REM_WARN);
  end

  assign WdtExpired  = expired_q;
  assign WdtResetReq = resetreq_q;
  assign WdtBadCmd   = badcmd_q;
  assign WdtRemain   = remain_q;

endmodule

// File: tb/tb_bios_wdt_timer.sv
// ---------------------------------------------------------------------------
// tb_bios_wdt_timer
//   This is a directed testbench for bios_wdt_timer. It uses PRESCALE=4,
//   TIMEOUT=5 and WARN=2. Inputs change 1 time unit after a rising edge.
//   Outputs are checked at the same point, which is well away from the
//   active edge. A command toggle driven at that point is applied on the
//   second rising edge that follows it.
// ---------------------------------------------------------------------------
module tb_bios_wdt_timer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] sig;
  logic       en, warn, expd, rreq, bad;
  logic [7:0] remain;

  int unsigned tests = 0;
  int unsigned fails = 0;

  bios_wdt_timer #(
    .PRESCALE(4),
    .REMW    (8),
    .TIMEOUT (5),
    .WARN    (2)
  ) dut (
    .CLK32768       (clk),
    .MainResetN     (rst_n),
    .bCPUWrWdtRegSig(sig),
    .WdtEnable      (en),
    .WdtWarn        (warn),
    .WdtExpired     (expd),
    .WdtResetReq    (rreq),
    .WdtBadCmd      (bad),
    .WdtRemain      (remain)
  );

  always #5 clk = ~clk;

  task automatic step(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic toggle(input logic [4:0] mask);
    sig = sig ^ mask;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // The flag arguments are packed as {en,warn,expd,rreq,bad}.
  task automatic chk_all(input string tag, input logic [4:0] flags, input logic [7:0] rem);
    chk({tag, ".en"},     32'(en),     32'(flags[4]));
    chk({tag, ".warn"},   32'(warn),   32'(flags[3]));
    chk({tag, ".exp"},    32'(expd),   32'(flags[2]));
    chk({tag, ".rreq"},   32'(rreq),   32'(flags[1]));
    chk({tag, ".bad"},    32'(bad),    32'(flags[0]));
    chk({tag, ".remain"}, 32'(remain), 32'(rem));
  endtask

  initial begin
    rst_n = 1'b0;
    sig   = '0;
    step(3);
    chk_all("reset", 5'b00000, 8'd5);
    rst_n = 1'b1;
    step(2);
    chk_all("idle", 5'b00000, 8'd5);

    // Test 1: arm, then run until expiry.
    toggle(5'b00001);
    step(1);
    chk("arm_not_yet.en", 32'(en), 32'd0);
    step(1);
    chk_all("armed", 5'b10000, 8'd5);
    step(12);
    chk_all("warn_at_2", 5'b11000, 8'd2);
    step(7);
    chk_all("last_tick", 5'b11000, 8'd1);
    step(1);
    chk_all("expired", 5'b00110, 8'd0);
    step(1);
    chk_all("pulse_done", 5'b00100, 8'd0);
    // A kick in the EXPIRED state is ignored.
    toggle(5'b00010);
    step(2);
    chk_all("kick_in_expired", 5'b00100, 8'd0);
    // CLEAR while EXPIRED clears the flag. The state stays the same.
    toggle(5'b01000);
    step(2);
    chk_all("clear_in_expired", 5'b00000, 8'd0);

    // Test 2: re-arm, then kick when WdtRemain is 2.
    toggle(5'b00001);
    step(2);
    chk_all("rearm", 5'b10000, 8'd5);
    step(12);
    chk_all("pre_kick", 5'b11000, 8'd2);
    toggle(5'b00010);
    step(2);
    chk_all("kicked", 5'b10000, 8'd5);
    step(19);
    chk_all("kick_last_tick", 5'b11000, 8'd1);
    step(1);
    chk_all("kick_expired", 5'b00110, 8'd0);

    // Test 3: STOP and KICK in the same cycle while running.
    toggle(5'b00001);
    step(2);
    chk_all("arm3", 5'b10100, 8'd5);
    step(3);
    toggle(5'b00110);
    step(2);
    chk_all("stop_kick", 5'b00100, 8'd5);
    toggle(5'b00010);
    step(2);
    chk_all("kick_in_idle", 5'b00100, 8'd5);
    step(6);
    chk_all("idle_held", 5'b00100, 8'd5);

    // Test 4: BADCMD and CLEAR.
    toggle(5'b10000);
    step(2);
    chk_all("badcmd", 5'b00101, 8'd5);
    toggle(5'b01000);
    step(2);
    chk_all("clear", 5'b00000, 8'd5);
    toggle(5'b11000);
    step(2);
    chk_all("bad_beats_clear", 5'b00001, 8'd5);
    toggle(5'b01000);
    step(2);
    chk("clear2.bad", 32'(bad), 32'd0);

    // Test 5: a KICK, and then a STOP, each on the final tick edge.
    toggle(5'b00001);
    step(2);
    chk_all("arm5", 5'b10000, 8'd5);
    step(18);
    chk_all("pre_final_kick", 5'b11000, 8'd1);
    toggle(5'b00010);
    step(2);
    chk_all("kick_on_final", 5'b10000, 8'd5);
    step(1);
    chk("kick_on_final_after.rreq", 32'(rreq), 32'd0);
    step(17);
    chk_all("pre_final_stop", 5'b11000, 8'd1);
    toggle(5'b00100);
    step(2);
    chk_all("stop_on_final", 5'b00000, 8'd5);
    step(1);
    chk_all("stop_on_final_after", 5'b00000, 8'd5);

    // Test 6: reset in the middle of RUN.
    toggle(5'b10001);
    step(2);
    chk_all("arm6", 5'b10001, 8'd5);
    step(8);
    chk_all("mid_run", 5'b10001, 8'd3);
    rst_n = 1'b0;
    #1;
    chk_all("async_reset", 5'b00000, 8'd5);
    sig = '0;
    step(2);
    rst_n = 1'b1;
    step(4);
    chk_all("post_reset", 5'b00000, 8'd5);
    step(25);
    chk_all("post_reset_quiet", 5'b00000, 8'd5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
